// File: rtl/bus_interconnect.sv
// Single-master, NumSlaves-way memory-mapped interconnect with per-slave req/ack handshake and bus-error responses.
// Latency: mapped access ready 2+n cycles after request (n = slave wait-states), unmapped ready after 1 cycle.
// Backpressure: one transaction at a time; master strobes are ignored while busy_o=1. Timeout path only when BUS_TIMEOUT_EN is defined.
module bus_interconnect #(
    parameter int unsigned NumSlaves     = 2,
    parameter int unsigned AddrWidth     = 30,
    parameter int unsigned DataWidth     = 32,
    parameter logic [NumSlaves*AddrWidth-1:0] SlaveBase = {30'h3C00_0000, 30'h0},
    parameter logic [NumSlaves*AddrWidth-1:0] SlaveMask = {30'h3C00_0000, 30'h3C00_0000},
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [AddrWidth-1:0]           addr_i,
    input  logic [DataWidth-1:0]           wdata_i,
    input  logic [DataWidth/8-1:0]         byte_en_i,
    input  logic                           wr_i,
    input  logic                           addr_strobe_i,
    output logic [DataWidth-1:0]           rdata_o,
    output logic                           ready_o,
    output logic                           err_o,
    output logic                           busy_o,
    output logic [AddrWidth-1:0]           err_addr_o,
    output logic [AddrWidth-1:0]           s_addr_o,
    output logic [DataWidth-1:0]           s_wdata_o,
    output logic [DataWidth/8-1:0]         s_byte_en_o,
    output logic [NumSlaves-1:0]           s_strobe_o,
    output logic [NumSlaves-1:0]           s_wr_o,
    input  logic [NumSlaves*DataWidth-1:0] s_rdata_i,
    input  logic [NumSlaves-1:0]           s_ack_i
);

    localparam int unsigned BeWidth = DataWidth / 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t                 state;
    logic [NumSlaves-1:0]   sel_q;
    logic                   wr_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [BeWidth-1:0]     byte_en_q;
    logic [NumSlaves-1:0]   strobe_q;
    logic [NumSlaves-1:0]   s_wr_q;
    logic [DataWidth-1:0]   rdata_q;
    logic                   ready_q;
    logic                   err_q;
    logic [AddrWidth-1:0]   err_addr_q;

    logic [NumSlaves-1:0]   hit_sel;
    logic [DataWidth-1:0]   sel_rdata;
    logic                   ack_hit;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
    logic [CntWidth-1:0]    wait_cnt;
`else
    logic [15:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 16'(TimeoutCycles);
`endif

    // Walk from the top index down so the lowest matching window wins.
    always_comb begin
        hit_sel = '0;
        for (int k = NumSlaves - 1; k >= 0; k--) begin
            if ((addr_i & SlaveMask[k*AddrWidth +: AddrWidth]) ==
                (SlaveBase[k*AddrWidth +: AddrWidth] & SlaveMask[k*AddrWidth +: AddrWidth])) begin
                hit_sel    = '0;
                hit_sel[k] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < NumSlaves; k++) begin
            if (sel_q[k]) begin
                sel_rdata = sel_rdata | s_rdata_i[k*DataWidth +: DataWidth];
            end
        end
    end

    assign ack_hit = |(s_ack_i & sel_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            byte_en_q  <= '0;
            strobe_q   <= '0;
            s_wr_q     <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
`ifdef BUS_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            // Response and strobe outputs are single-cycle pulses by default.
            strobe_q <= '0;
            s_wr_q   <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (addr_strobe_i) begin
                        addr_q    <= addr_i;
                        wdata_q   <= wdata_i;
                        byte_en_q <= byte_en_i;
                        wr_q      <= wr_i;
                        sel_q     <= hit_sel;
                        if (|hit_sel) begin
                            state    <= ISSUE;
                            strobe_q <= hit_sel;
                            s_wr_q   <= wr_i ? hit_sel : '0;
                        end else begin
                            state      <= RESP;
                            ready_q    <= 1'b1;
                            err_q      <= 1'b1;
                            err_addr_q <= addr_i;
                        end
                    end
                end
                ISSUE: begin
                    if (ack_hit) begin
                        state   <= RESP;
                        ready_q <= 1'b1;
                        rdata_q <= wr_q ? '0 : sel_rdata;
                    end else begin
                        state <= WAIT;
`ifdef BUS_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (ack_hit) begin
                        state   <= RESP;
                        ready_q <= 1'b1;
                        rdata_q <= wr_q ? '0 : sel_rdata;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (wait_cnt == CntWidth'(TimeoutCycles - 1)) begin
                        state      <= RESP;
                        ready_q    <= 1'b1;
                        err_q      <= 1'b1;
                        err_addr_q <= addr_q;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign rdata_o     = rdata_q;
    assign ready_o     = ready_q;
    assign err_o       = err_q;
    assign busy_o      = (state != IDLE);
    assign err_addr_o  = err_addr_q;
    assign s_addr_o    = addr_q;
    assign s_wdata_o   = wdata_q;
    assign s_byte_en_o = byte_en_q;
    assign s_strobe_o  = strobe_q;
    assign s_wr_o      = s_wr_q;

endmodule

// File: tb/tb_bus_interconnect.sv
// Randomized bench for bus_interconnect against a transaction-level latency/response model.
// Expects TimeoutCycles=4 when BUS_TIMEOUT_EN is defined.
module tb_bus_interconnect;

    localparam int TO = 4;
`ifdef BUS_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  byte_en_i;
    logic        wr_i;
    logic        addr_strobe_i;
    logic [31:0] rdata_o;
    logic        ready_o;
    logic        err_o;
    logic        busy_o;
    logic [29:0] err_addr_o;
    logic [29:0] s_addr_o;
    logic [31:0] s_wdata_o;
    logic [3:0]  s_byte_en_o;
    logic [1:0]  s_strobe_o;
    logic [1:0]  s_wr_o;
    logic [63:0] s_rdata_i;
    logic [1:0]  s_ack_i;

    bus_interconnect #(.TimeoutCycles(TO)) dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .wdata_i(wdata_i), .byte_en_i(byte_en_i),
        .wr_i(wr_i), .addr_strobe_i(addr_strobe_i), .rdata_o(rdata_o), .ready_o(ready_o),
        .err_o(err_o), .busy_o(busy_o), .err_addr_o(err_addr_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_byte_en_o(s_byte_en_o), .s_strobe_o(s_strobe_o),
        .s_wr_o(s_wr_o), .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [29:0] m_err_addr = '0;
    logic [29:0] win_base [2] = '{30'h0, 30'h3C00_0000};
    logic [29:0] win_mask [2] = '{30'h3C00_0000, 30'h3C00_0000};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_slave(input logic [29:0] a);
        for (int k = 0; k < 2; k++)
            if ((a & win_mask[k]) == (win_base[k] & win_mask[k])) return k;
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  64'(busy_o), 64'd0);
        check({tag, "_resp"},  {rdata_o, 30'(0), ready_o, err_o}, 64'd0);
        check({tag, "_eaddr"}, 64'(err_addr_o), 64'd0);
        check({tag, "_saddr"}, {s_addr_o, s_byte_en_o, s_strobe_o, s_wr_o}, 64'd0);
        check({tag, "_swdat"}, 64'(s_wdata_o), 64'd0);
    endtask

    // One master transaction; ack from the target slave arrives in cycle 1+dly.
    task automatic run_txn(input string tag, input logic [29:0] a, input logic w,
                           input logic [31:0] wd, input logic [3:0] be, input int dly, input bit noise);
        int sl, exp_rdy, rdy_cyc, strb_cyc, strb_cnt, wr_cnt, wd_bad, busy1;
        logic [31:0] exp_rd, got_rd;
        logic exp_err, got_err;
        logic [1:0] strb_val, wr_val;
        logic [29:0] got_eaddr, got_saddr;
        logic [3:0] got_be;
        sl = ref_slave(a);
        exp_err = 1'b0; exp_rd = '0;
        if (sl < 0) begin
            exp_rdy = 1; exp_err = 1'b1;
        end else if (TIMEOUT_ON && dly > TO) begin
            exp_rdy = 2 + TO; exp_err = 1'b1;
        end else begin
            exp_rdy = 2 + dly;
        end
        if (exp_err) m_err_addr = a;
        rdy_cyc = -1; strb_cyc = -1; strb_cnt = 0; wr_cnt = 0; wd_bad = 0; busy1 = 0;
        strb_val = '0; wr_val = '0; got_rd = '0; got_err = 1'b0;
        got_eaddr = '0; got_saddr = '0; got_be = '0;
        @(negedge clk);
        addr_i = a; wdata_i = wd; byte_en_i = be; wr_i = w; addr_strobe_i = 1'b1;
        s_ack_i = '0; s_rdata_i = {$urandom, $urandom};
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) busy1 = int'(busy_o);
            if (s_strobe_o != 0) begin
                strb_cnt++;
                if (strb_cyc < 0) begin strb_cyc = c; strb_val = s_strobe_o; end
            end
            if (s_wr_o != 0) begin wr_cnt++; wr_val = s_wr_o; end
            if (s_wdata_o !== wd) wd_bad++;
            addr_strobe_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin addr_i = 30'($urandom); wr_i = 1'($urandom); end
            s_ack_i = '0;
            s_rdata_i = {$urandom, $urandom};
            if (ready_o) begin
                rdy_cyc = c; got_rd = rdata_o; got_err = err_o;
                got_eaddr = err_addr_o; got_saddr = s_addr_o; got_be = s_byte_en_o;
                addr_strobe_i = 1'b0;
                break;
            end
            if (sl >= 0 && c == 1 + dly) begin
                s_ack_i[sl] = 1'b1;
                exp_rd = w ? 32'h0 : s_rdata_i[sl*32 +: 32];
            end
            if (noise && sl >= 0) s_ack_i[1-sl] = 1'($urandom_range(0, 1));
        end
        if (rdy_cyc < 0) check({tag, "_no_ready"}, 64'd0, 64'd1);
        check({tag, "_rdy_cyc"}, 64'(rdy_cyc), 64'(exp_rdy));
        check({tag, "_err"}, 64'(got_err), 64'(exp_err));
        check({tag, "_rdata"}, 64'(got_rd), 64'(exp_err ? 32'h0 : exp_rd));
        check({tag, "_eaddr"}, 64'(got_eaddr), 64'(m_err_addr));
        check({tag, "_saddr"}, {got_saddr, got_be}, {a, be});
        check({tag, "_busy"}, 64'(busy1), 64'd1);
        check({tag, "_wdat_stable"}, 64'(wd_bad), 64'd0);
        if (sl >= 0) begin
            check({tag, "_strb"}, {32'(strb_cyc), 30'(0), strb_val}, {32'd1, 30'(0), 2'(1 << sl)});
            check({tag, "_strb_cnt"}, 64'(strb_cnt), 64'd1);
            check({tag, "_wr"}, {32'(wr_cnt), 30'(0), wr_val}, w ? {32'd1, 30'(0), 2'(1 << sl)} : 64'd0);
        end else begin
            check({tag, "_nostrb"}, 64'(strb_cnt + wr_cnt), 64'd0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [29:0] a;
        int cls;
        rst = 1'b1; addr_i = '0; wdata_i = '0; byte_en_i = '0; wr_i = 1'b0;
        addr_strobe_i = 1'b0; s_rdata_i = '0; s_ack_i = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        run_txn("rd_s0_zw", 30'h000_0010, 1'b0, 32'h0, 4'hF, 0, 1'b0);
        run_txn("wr_s1_w3", 30'h3C00_0000, 1'b1, 32'h0000_0041, 4'b0001, 3, 1'b0);
        run_txn("unmapped", 30'h1000_0000, 1'b0, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
        run_txn("noise_s0", 30'h000_0100, 1'b0, 32'h5555_AAAA, 4'hF, 3, 1'b1);
        run_txn("ack_last", 30'h3C00_0040, 1'b0, 32'h0, 4'hF, TO, 1'b0);
        if (TIMEOUT_ON) run_txn("never_ack", 30'h3C00_0080, 1'b0, 32'h0, 4'hF, 1000, 1'b0);
        else            run_txn("long_wait", 30'h3C00_0080, 1'b0, 32'h0, 4'hF, 30, 1'b0);

        // Reset in the middle of a WAIT.
        @(negedge clk);
        addr_i = 30'h3C00_0123; wdata_i = 32'hCAFE_F00D; byte_en_i = 4'hF; wr_i = 1'b1;
        addr_strobe_i = 1'b1;
        @(negedge clk);
        addr_strobe_i = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", 64'(busy_o), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_err_addr = '0;
        check_all_zero("mid_rst");
        run_txn("post_rst", 30'h000_0444, 1'b0, 32'h0, 4'h3, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            cls = $urandom_range(0, 2);
            a = 30'($urandom);
            a[29:26] = (cls == 0) ? 4'h0 : (cls == 1) ? 4'hF : 4'($urandom_range(1, 14));
            run_txn("rand", a, 1'($urandom), $urandom, 4'($urandom),
                    $urandom_range(0, 7), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
